vga_sync_rx: RTL and testbench

//  Receive-side counterpart of the VGA timing generator: samples hs/vs (same clk_25 domain),

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/sync_edge_meter.sv | 62 ++++++
 rtl/vga_sync_rx.sv | 143 ++++++++++++++
 tb/tb_vga_sync_rx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and sync receiver state encoding.
// Shared by vgaSync and vga_sync_rx.
package vga_timing_pkg;

  localparam int H_TOTAL     = 800;
  localparam int H_SYNC      = 96;
  localparam int H_BP        = 48;
  localparam int H_ACT       = 640;
  localparam int V_TOTAL     = 525;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 33;
  localparam int V_ACT       = 480;
  localparam int LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  // CRC-16-CCITT, one byte per call, MSB first
  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  d
  );
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_edge_meter.sv
// Active-low sync edge detector with saturating counter and
// width/period checks; tick gates counting (1 for H, hfall for V).
module sync_edge_meter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = 800,
  parameter int SYNC  = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic       tick,
  output logic [9:0] cnt,
  output logic       fall,
  output logic       err
);

  logic        sig_q;
  logic        pend_q;
  logic        first_q;
  logic [9:0]  cnt_q;
  logic        rise;
  logic        clr;
  logic        sat;
  logic [10:0] len;

  assign fall = sig_q & ~sig;
  assign rise = ~sig_q & sig;
  // a fall between ticks restarts the count on the next tick
  assign clr  = tick & (fall | pend_q);
  assign sat  = tick & ~clr & (cnt_q == 10'd1022);
  assign len  = (cnt_q == 10'h3ff) ? 11'd1023
                                   : {1'b0, cnt_q} + 11'd1;

  always_comb begin
    cnt = cnt_q;
    if (clr)
      cnt = '0;
    else if (tick && cnt_q != 10'h3ff)
      cnt = cnt_q + 10'd1;
  end

  assign err = (fall & ~first_q & (len != 11'(TOTAL)))
             | (rise & (cnt_q != 10'(SYNC - 1)))
             | sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q   <= 1'b1;
      pend_q  <= 1'b0;
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sig_q  <= sig;
      cnt_q  <= cnt;
      pend_q <= (fall | pend_q) & ~tick;
      if (fall)     first_q <= 1'b0;
      else if (sat) first_q <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures hs/vs, locks, regenerates hc/vc/de.
// Optional SYNC_RX_PIXEL_CRC_EN adds a per-frame CRC of active pixels.
module vga_sync_rx #(
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int H_ACT       = vga_timing_pkg::H_ACT,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int V_ACT       = vga_timing_pkg::V_ACT,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [7:0]  rgb,
  output logic        locked,
  output logic [9:0]  hc_rx,
  output logic [9:0]  vc_rx,
  output logic        de,
  output logic        frame_start,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] frame_crc
);
  import vga_timing_pkg::*;

  localparam int HA0 = H_SYNC + H_BP;
  localparam int VA0 = V_SYNC + V_BP;

  sync_state_t state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        bad_q, bad_d;
  logic [9:0]  h_cnt, v_cnt;
  logic        hfall, vfall;
  logic        h_raw, v_raw;
  logic        any_err;

  sync_edge_meter #(.TOTAL(H_TOTAL), .SYNC(H_SYNC)) u_h (
    .clk  (clk),
    .rst  (rst),
    .sig  (hs),
    .tick (1'b1),
    .cnt  (h_cnt),
    .fall (hfall),
    .err  (h_raw)
  );

  sync_edge_meter #(.TOTAL(V_TOTAL), .SYNC(V_SYNC)) u_v (
    .clk  (clk),
    .rst  (rst),
    .sig  (vs),
    .tick (hfall),
    .cnt  (v_cnt),
    .fall (vfall),
    .err  (v_raw)
  );

  assign h_err       = ~rst & (state_q != SEARCH) & h_raw;
  assign v_err       = ~rst & (state_q != SEARCH) & v_raw;
  assign any_err     = h_err | v_err;
  assign frame_start = ~rst & vfall;
  assign locked      = (state_q == LOCKED);
  assign hc_rx       = rst ? '0 : h_cnt;
  assign vc_rx       = rst ? '0 : v_cnt;

  assign de = locked
            & (h_cnt >= 10'(HA0)) & (h_cnt <= 10'(HA0 + H_ACT - 1))
            & (v_cnt >= 10'(VA0)) & (v_cnt <= 10'(VA0 + V_ACT - 1));

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    unique case (state_q)
      SEARCH: if (vfall) begin
        state_d = CHECK;
        good_d  = '0;
        bad_d   = 1'b0;
      end
      CHECK: begin
        if (any_err) begin
          bad_d  = 1'b1;
          good_d = '0;
        end
        if (vfall) begin
          bad_d = 1'b0;
          if (any_err || bad_q) begin
            good_d = '0;
          end else if (good_q + 4'd1 == 4'(LOCK_FRAMES)) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
      end
      LOCKED: if (any_err) begin
        state_d = SEARCH;
        good_d  = '0;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      good_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

`ifdef SYNC_RX_PIXEL_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] frame_crc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= '0;
    end else if (frame_start) begin
      frame_crc_q <= crc_q;
      crc_q       <= 16'hFFFF;
    end else if (de) begin
      crc_q <= crc16_byte(crc_q, rgb);
    end
  end

  assign frame_crc = frame_crc_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^rgb;
  assign frame_crc  = '0;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx with a scaled-down timing generator.
// Scenario table plus hand-written lock/error/saturation/reset sequences.
module tb_vga_sync_rx;

  localparam int HT = 40;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HA = 30;
  localparam int VT = 12;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VA = 6;
  localparam int LF = 2;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic [7:0]  rgb = 8'hE0;
  logic        locked, de, frame_start, h_err, v_err;
  logic [9:0]  hc_rx, vc_rx;
  logic [15:0] frame_crc;

  int total = 0;
  int bad = 0;

  int ghc = 0, gvc = 0, line_len = HT, short_vc = -1;
  int hs_w = HS, vs_w = VS;
  bit ov = 1'b0, track = 1'b0;

  int n_herr, n_verr, n_de, n_fs, first_de_h, first_de_v;
  bit locked_seen;

  logic        l_locked, l_fs, l_herr, l_de;
  logic [9:0]  l_hc;
  logic [15:0] l_crc;
  logic [40:0] l_all;

  typedef struct {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       de;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int hw;
    int vw;
    bit lock;
    bit herr;
    bit verr;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  vga_sync_rx #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACT(VA),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hs          (hs),
    .vs          (vs),
    .rgb         (rgb),
    .locked      (locked),
    .hc_rx       (hc_rx),
    .vc_rx       (vc_rx),
    .de          (de),
    .frame_start (frame_start),
    .h_err       (h_err),
    .v_err       (v_err),
    .frame_crc   (frame_crc)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic bit in_act(input int h, input int v);
    return (h >= HS + HB) && (h <= HS + HB + HA - 1)
        && (v >= VS + VB) && (v <= VS + VB + VA - 1);
  endfunction

  function automatic logic [15:0] crc_model(input int n, input logic [7:0] b);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic clr_mon();
    n_herr = 0; n_verr = 0; n_de = 0; n_fs = 0;
    first_de_h = -1; first_de_v = -1;
    locked_seen = 1'b0;
  endtask

  // one clock: drive generator state, sample outputs, advance generator
  task automatic cyc();
    exp_t e;
    hs = ov ? 1'b1 : (ghc >= hs_w);
    vs = ov ? 1'b1 : (gvc >= vs_w);
    if (track) begin
      e.hc = 10'(ghc);
      e.vc = 10'(gvc);
      e.de = in_act(ghc, gvc);
      sb.push_back(e);
    end
    #2;
    if (h_err) n_herr++;
    if (v_err) n_verr++;
    if (locked) locked_seen = 1'b1;
    if (frame_start) n_fs++;
    if (de) begin
      if (n_de == 0) begin
        first_de_h = int'(hc_rx);
        first_de_v = int'(vc_rx);
      end
      n_de++;
    end
    l_locked = locked; l_fs = frame_start; l_herr = h_err;
    l_de = de; l_hc = hc_rx; l_crc = frame_crc;
    l_all = {locked, hc_rx, vc_rx, de, frame_start, h_err, v_err, frame_crc};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_hc", hc_rx, e.hc);
      chk("sb_vc", vc_rx, e.vc);
      chk("sb_de", de, e.de);
      chk("sb_locked", locked, 1);
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      if (ghc >= line_len - 1) begin
        ghc = 0;
        line_len = HT;
        gvc = (gvc == VT - 1) ? 0 : gvc + 1;
        if (gvc == short_vc) begin
          line_len = HT - 1;
          short_vc = -1;
        end
      end else begin
        ghc++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ov = 1'b0; track = 1'b0;
    hs_w = HS; vs_w = VS;
    ghc = 0; gvc = 0; line_len = HT; short_vc = -1;
    cyc();
    cyc();
  endtask

  // run until the n-th generator frame start has been sampled
  task automatic to_fs(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 20 * FRAME; i++) begin
      if (ghc == 0 && gvc == 0) seen++;
      cyc();
      if (seen == n) return;
    end
    total++; bad++;
    $display("FAIL to_fs: timeout waiting for frame start %0d", n);
  endtask

  task automatic to_pos(input int h, input int v);
    bit hit;
    for (int i = 0; i < 4 * FRAME; i++) begin
      hit = (ghc == h) && (gvc == v);
      cyc();
      if (hit) return;
    end
    total++; bad++;
    $display("FAIL to_pos: timeout waiting for %0d,%0d", h, v);
  endtask

  initial begin
    logic [15:0] crc_exp;
`ifdef SYNC_RX_PIXEL_CRC_EN
    crc_exp = crc_model(HA * VA, 8'hE0);
`else
    crc_exp = 16'h0000;
`endif
    tbl[0] = '{HS,     VS,     1'b1, 1'b0, 1'b0};
    tbl[1] = '{HS - 1, VS,     1'b0, 1'b1, 1'b0};
    tbl[2] = '{HS + 1, VS,     1'b0, 1'b1, 1'b0};
    tbl[3] = '{HS,     VS + 1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{HS,     VS - 1, 1'b0, 1'b0, 1'b1};

    @(posedge clk);
    #1;
    do_reset();
    chk("reset_outputs", l_all, 0);

    // lock sequence, then one cycle-exact tracked frame
    rst = 1'b0;
    clr_mon();
    to_fs(3);
    chk("fs3_pulse", l_fs, 1);
    chk("fs3_not_yet_locked", l_locked, 0);
    cyc();
    chk("locked_after_fs3", l_locked, 1);
    chk("lock_errs", n_herr + n_verr, 0);
    chk("lock_fs_count", n_fs, 3);
    clr_mon();
    track = 1'b1;
    repeat (FRAME) cyc();
    track = 1'b0;
    chk("de_count", n_de, HA * VA);
    chk("first_de_h", first_de_h, HS + HB);
    chk("first_de_v", first_de_v, VS + VB);
    chk("track_errs", n_herr + n_verr, 0);
    cyc();
    chk("frame_crc", l_crc, crc_exp);

    // one short line while locked
    clr_mon();
    short_vc = 5;
    to_pos(0, 6);
    chk("short_herr", l_herr, 1);
    chk("short_still_locked", l_locked, 1);
    cyc();
    chk("short_unlocked", l_locked, 0);
    to_fs(3);
    chk("relock_fs3", l_locked, 0);
    cyc();
    chk("relocked", l_locked, 1);
    chk("short_herr_count", n_herr, 1);
    chk("short_verr_count", n_verr, 0);

    // reset in the middle of active video
    to_pos(12, 4);
    chk("mid_de", l_de, 1);
    rst = 1'b1;
    cyc();
    cyc();
    chk("mid_reset_outputs", l_all, 0);

    // hs stuck high until the counter saturates
    do_reset();
    rst = 1'b0;
    to_fs(3);
    cyc();
    chk("sat_pre_locked", l_locked, 1);
    to_pos(10, 5);
    ov = 1'b1;
    clr_mon();
    repeat (1100) cyc();
    chk("sat_herr_count", n_herr, 1);
    chk("sat_verr_count", n_verr, 0);
    chk("sat_unlocked", l_locked, 0);
    chk("sat_hc", l_hc, 1023);
    ov = 1'b0;

    // sync-width scenario table
    for (int i = 0; i < 5; i++) begin
      do_reset();
      hs_w = tbl[i].hw;
      vs_w = tbl[i].vw;
      rst = 1'b0;
      clr_mon();
      repeat (4 * FRAME) cyc();
      chk($sformatf("vec%0d_lock", i), locked_seen, tbl[i].lock);
      chk($sformatf("vec%0d_herr", i), n_herr > 0, tbl[i].herr);
      chk($sformatf("vec%0d_verr", i), n_verr > 0, tbl[i].verr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
